// File: rtl/pcs_tx_pkg.sv
// Shared code-group constants, FSM encoding and datapath types for the 1000BASE-X PCS transmit path.
// The EXTEND state exists only when CARRIER_EXT_EN is defined.
package pcs_tx_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // comma, first half of an idle pair
    localparam logic [7:0] K27_7 = 8'hFB;  // /S/
    localparam logic [7:0] K29_7 = 8'hFD;  // /T/
    localparam logic [7:0] K23_7 = 8'hF7;  // /R/
    localparam logic [7:0] K30_7 = 8'hFE;  // /V/
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;

    // TXD value that, together with TX_ER and no TX_EN, requests carrier extension
    localparam logic [7:0] EXT_CODE = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE_K = 3'd0,
        ST_IDLE_D = 3'd1,
        ST_SOP    = 3'd2,
        ST_DATA   = 3'd3,
        ST_EOP_T  = 3'd4,
        ST_EOP_R1 = 3'd5,
        ST_EOP_R2 = 3'd6
`ifdef CARRIER_EXT_EN
        ,
        ST_EXTEND = 3'd7
`endif
    } tx_state_e;

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] txd;
    } gmii_t;

    typedef struct packed {
        logic [7:0] code;
        logic       is_k;
    } cg_t;

    function automatic cg_t mk_cg(input logic [7:0] c, input logic k);
        cg_t r;
        r.code = c;
        r.is_k = k;
        return r;
    endfunction

endpackage

// File: rtl/pcs_tx_align_buf.sv
// One-deep skew register for the captured GMII beat; bypass selects the direct or delayed beat
// so a packet whose start lands on an odd slot can be pushed back by one code-group.
module pcs_tx_align_buf
    import pcs_tx_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  gmii_t din,
    input  logic  skew_sel,
    output logic  dly_en,
    output gmii_t dout
);

    gmii_t dly_q;
    gmii_t dly_d;

    always_comb begin
        dly_d = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign dly_en = dly_q.en;
    assign dout   = skew_sel ? dly_q : din;

endmodule

// File: rtl/pcs_tx_oset_gen.sv
// 1000BASE-X PCS transmit ordered-set generator: GMII beats in, registered code-groups out.
// Optional carrier extension (EXTEND state) is compiled in with the CARRIER_EXT_EN macro.
module pcs_tx_oset_gen
    import pcs_tx_pkg::*;
#(
    parameter int         MIN_IDLE_PAIRS = 2,
    parameter logic [7:0] IDLE_D_CODE    = D16_2,
    parameter int         IDLE_CNT_W     = 4
) (
    input  logic       GTX_CLK,
    input  logic       RESET,
    input  logic       TX_EN,
    input  logic       TX_ER,
    input  logic [7:0] TXD,
    output logic [7:0] tx_code_group,
    output logic       tx_is_k,
    output logic       tx_even,
    output logic       tx_transmitting,
    output logic       tx_ipg_err
);

    if ((2 ** IDLE_CNT_W) - 1 < MIN_IDLE_PAIRS) begin : g_bad_cfg
        $error("IDLE_CNT_W too narrow to hold MIN_IDLE_PAIRS");
    end

    localparam logic [IDLE_CNT_W-1:0] MIN_CNT = IDLE_CNT_W'(MIN_IDLE_PAIRS);
    localparam logic [IDLE_CNT_W-1:0] CNT_MAX = '1;

    tx_state_e             state_q, state_d;
    gmii_t                 s1_q, s1_d;
    logic                  skew_q, skew_d;
    logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  even_q, even_d;
    cg_t                   out_q, out_d;
    logic                  trans_q, trans_d;
    logic                  err_q, err_d;

    gmii_t cur;
    logic  dly_en;

    pcs_tx_align_buf u_align (
        .clk      (GTX_CLK),
        .rst      (RESET),
        .din      (s1_q),
        .skew_sel (skew_q),
        .dly_en   (dly_en),
        .dout     (cur)
    );

    // Next-state: state_q describes the code-group currently on the output,
    // state_d the one about to be registered into the next slot.
    always_comb begin
        s1_d    = '{en: TX_EN, er: TX_ER, txd: TXD};
        state_d = state_q;
        skew_d  = skew_q;
        even_d  = ~even_q;

        case (state_q)
            ST_IDLE_K: state_d = ST_IDLE_D;
            ST_IDLE_D: begin
                // A beat parked in the skew register means the start arrived on an odd slot.
                if (dly_en) begin
                    state_d = ST_SOP;
                    skew_d  = 1'b1;
                end else if (s1_q.en) begin
                    state_d = ST_SOP;
                    skew_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE_K;
                end
            end
            ST_SOP:    state_d = cur.en ? ST_DATA : ST_EOP_T;
            ST_DATA: begin
                if (cur.en) begin
                    state_d = ST_DATA;
`ifdef CARRIER_EXT_EN
                end else if (cur.er && cur.txd == EXT_CODE) begin
                    state_d = ST_EXTEND;
`endif
                end else begin
                    state_d = ST_EOP_T;
                end
            end
            ST_EOP_T:  state_d = ST_EOP_R1;
            ST_EOP_R1: begin
                if (even_q) begin
                    state_d = ST_EOP_R2;
                end else if (s1_q.en) begin
                    state_d = ST_SOP;
                    skew_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE_K;
                end
            end
            ST_EOP_R2: begin
                if (s1_q.en) begin
                    state_d = ST_SOP;
                    skew_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE_K;
                end
            end
`ifdef CARRIER_EXT_EN
            ST_EXTEND: begin
                // Extension already stands in for /T/; leaving goes straight to /R/ alignment.
                state_d = (!cur.en && cur.er) ? ST_EXTEND : ST_EOP_R1;
            end
`endif
            default:   state_d = ST_IDLE_K;
        endcase
    end

    // Output decode and bookkeeping for the slot being entered.
    always_comb begin
        out_d   = mk_cg(K28_5, 1'b1);
        cnt_d   = cnt_q;
        trans_d = 1'b1;
        err_d   = 1'b0;

        case (state_d)
            ST_IDLE_K: begin
                out_d   = mk_cg(K28_5, 1'b1);
                trans_d = 1'b0;
            end
            ST_IDLE_D: begin
                out_d   = mk_cg(IDLE_D_CODE, 1'b0);
                trans_d = 1'b0;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
            ST_SOP: begin
                out_d = mk_cg(K27_7, 1'b1);
                cnt_d = '0;
                // Coming from /R/ means the new preamble collided with the old tail.
                err_d = (state_q != ST_IDLE_D) || (cnt_q < MIN_CNT);
            end
            ST_DATA:   out_d = cur.er ? mk_cg(K30_7, 1'b1) : mk_cg(cur.txd, 1'b0);
            ST_EOP_T:  out_d = mk_cg(K29_7, 1'b1);
            ST_EOP_R1: out_d = mk_cg(K23_7, 1'b1);
            ST_EOP_R2: out_d = mk_cg(K23_7, 1'b1);
`ifdef CARRIER_EXT_EN
            ST_EXTEND: out_d = (cur.er && cur.txd != EXT_CODE) ? mk_cg(K30_7, 1'b1)
                                                                : mk_cg(K23_7, 1'b1);
`endif
            default:   out_d = mk_cg(K28_5, 1'b1);
        endcase
    end

    always_ff @(posedge GTX_CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE_K;
            s1_q    <= '0;
            skew_q  <= 1'b0;
            cnt_q   <= MIN_CNT;
            even_q  <= 1'b1;
            out_q   <= mk_cg(K28_5, 1'b1);
            trans_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            skew_q  <= skew_d;
            cnt_q   <= cnt_d;
            even_q  <= even_d;
            out_q   <= out_d;
            trans_q <= trans_d;
            err_q   <= err_d;
        end
    end

    assign tx_code_group   = out_q.code;
    assign tx_is_k         = out_q.is_k;
    assign tx_even         = even_q;
    assign tx_transmitting = trans_q;
    assign tx_ipg_err      = err_q;

endmodule

// File: tb/tb_pcs_tx_oset_gen.sv
module tb_pcs_tx_oset_gen;

    localparam int MIN_PAIRS = 2;
    localparam int NA        = 160;
    localparam int NC        = 100;

    logic       gclk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       tx_er;
    logic [7:0] txd;
    logic [7:0] cg;
    logic       is_k;
    logic       even;
    logic       trans;
    logic       ipg;

    pcs_tx_oset_gen #(
        .MIN_IDLE_PAIRS (MIN_PAIRS),
        .IDLE_D_CODE    (8'h50),
        .IDLE_CNT_W     (4)
    ) dut (
        .GTX_CLK         (gclk),
        .RESET           (rst),
        .TX_EN           (tx_en),
        .TX_ER           (tx_er),
        .TXD             (txd),
        .tx_code_group   (cg),
        .tx_is_k         (is_k),
        .tx_even         (even),
        .tx_transmitting (trans),
        .tx_ipg_err      (ipg)
    );

    always #5 gclk = ~gclk;

    logic       en_a  [NA];
    logic       er_a  [NA];
    logic [7:0] txd_a [NA];
    logic [7:0] e_cg  [NA];
    logic       e_k   [NA];
    logic       e_tr  [NA];
    logic       e_err [NA];

    int vectors     = 0;
    int miscompares = 0;
    int exp_vectors = 0;
    bit done        = 1'b0;

    initial begin
        #1000000;
        if (!done) begin
            miscompares++;
            $error("FAIL timeout: run did not complete");
            $finish;
        end
    end

    task automatic clear_stim();
        for (int i = 0; i < NA; i++) begin
            en_a[i]  = 1'b0;
            er_a[i]  = ($urandom_range(0, 3) == 0);
            txd_a[i] = 8'($urandom);
        end
    endtask

    task automatic add_pkt(input int a, input int len, input int er_idx, input bit rnd);
        for (int j = 0; j < len; j++) begin
            en_a[a+j] = 1'b1;
            er_a[a+j] = (j == er_idx);
            if (rnd)         txd_a[a+j] = 8'($urandom);
            else if (j < 7)  txd_a[a+j] = 8'h55;
            else if (j == 7) txd_a[a+j] = 8'hD5;
            else             txd_a[a+j] = 8'(j - 7);
        end
    endtask

    task automatic rand_stim();
        int c;
        int len;
        int eidx;
        c = int'($urandom_range(0, 3));
        while (c < NC - 30) begin
            len  = int'($urandom_range(1, 12));
            eidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            add_pkt(c, len, eidx, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                er_a[c+len]  = 1'b1;
                txd_a[c+len] = 8'h0F;
            end
            c = c + len + int'($urandom_range(1, 8));
        end
    endtask

    task automatic build_expect();
        int  f, base, c, a, b, s, lat, tslot, last_r;
        bit  trunc;
        for (int i = 0; i < NA; i++) begin
            e_cg[i]  = (i % 2 == 0) ? 8'hBC : 8'h50;
            e_k[i]   = (i % 2 == 0);
            e_tr[i]  = 1'b0;
            e_err[i] = 1'b0;
        end
        f    = 0;
        base = MIN_PAIRS;
        c    = 0;
        while (c < NA) begin
            if (!en_a[c]) begin
                c++;
                continue;
            end
            a = c;
            b = c;
            while (b + 1 < NA && en_a[b+1]) b++;
            c = b + 1;
            if (a + 2 < f) begin
                if (b < f - 2) continue;
                s     = f;
                lat   = 2;
                trunc = 1'b1;
            end else begin
                s     = (a % 2 == 0) ? a + 2 : a + 3;
                lat   = s - a;
                trunc = 1'b0;
            end
            e_err[s] = trunc || (base + (s - f) / 2 < MIN_PAIRS);
            e_cg[s]  = 8'hFB;
            e_k[s]   = 1'b1;
            for (int j = s - lat + 1; j <= b; j++) begin
                e_cg[j+lat] = er_a[j] ? 8'hFE : txd_a[j];
                e_k[j+lat]  = er_a[j];
            end
            tslot          = b + 1 + lat;
            e_cg[tslot]    = 8'hFD;
            e_k[tslot]     = 1'b1;
            e_cg[tslot+1]  = 8'hF7;
            e_k[tslot+1]   = 1'b1;
            last_r         = tslot + 1;
            if ((tslot + 1) % 2 == 0) begin
                e_cg[tslot+2] = 8'hF7;
                e_k[tslot+2]  = 1'b1;
                last_r        = tslot + 2;
            end
            for (int t = s; t <= last_r; t++) e_tr[t] = 1'b1;
            f    = last_r + 1;
            base = 0;
        end
    endtask

    initial begin
        rst   = 1'b1;
        tx_en = 1'b0;
        tx_er = 1'b0;
        txd   = 8'h00;
        for (int ep = 0; ep < 18; ep++) begin
            int nrun;
            bit ev;
            clear_stim();
            nrun = NC;
            case (ep)
                0: ;
                1: begin add_pkt(4, 12, -1, 0); add_pkt(31, 12, -1, 0); end
                2: begin add_pkt(5, 10, 4, 0);  add_pkt(30, 9, 4, 0);   end
                3: begin add_pkt(4, 6, -1, 1);  add_pkt(14, 4, -1, 1);  add_pkt(19, 6, -1, 1); end
                4: begin add_pkt(3, 30, -1, 1); nrun = 14; end
                default: rand_stim();
            endcase
            build_expect();
            exp_vectors += nrun + 1;
            rst   = 1'b1;
            tx_en = 1'b1;
            tx_er = 1'($urandom);
            txd   = 8'($urandom);
            @(posedge gclk);
            #1;
            vectors++;
            if ({cg, is_k, even, trans, ipg} !== {8'hBC, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $error("FAIL ep%0d reset: got cg=%h k=%b even=%b tr=%b ipg=%b",
                       ep, cg, is_k, even, trans, ipg);
            end
            rst = 1'b0;
            for (int t = 0; t < nrun; t++) begin
                ev = (t % 2 == 0);
                vectors++;
                assert ({cg, is_k, even, trans, ipg} === {e_cg[t], e_k[t], ev, e_tr[t], e_err[t]})
                else begin
                    miscompares++;
                    $error("FAIL ep%0d slot%0d: got cg=%h k=%b even=%b tr=%b ipg=%b, want cg=%h k=%b even=%b tr=%b ipg=%b",
                           ep, t, cg, is_k, even, trans, ipg, e_cg[t], e_k[t], ev, e_tr[t], e_err[t]);
                end
                tx_en = en_a[t];
                tx_er = er_a[t];
                txd   = txd_a[t];
                @(posedge gclk);
                #1;
            end
        end
        done = 1'b1;
        if (miscompares != 0 || vectors != exp_vectors)
            $error("FAIL summary: %0d miscompares, %0d/%0d vectors", miscompares, vectors, exp_vectors);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
